// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pkg
//  Description : Shared SDRAM controller definitions: the command encodings
//                driven on {csn,rasn,casn,wen} and the write FSM state enum.
//                Imported by the write, init and auto-refresh blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    // SDRAM command encodings, {csn, rasn, casn, wen}
    localparam logic [3:0] c_cmd_nop        = 4'b0111;
    localparam logic [3:0] c_cmd_active     = 4'b0011;
    localparam logic [3:0] c_cmd_write      = 4'b0100;
    localparam logic [3:0] c_cmd_burst_term = 4'b0110;
    localparam logic [3:0] c_cmd_precharge  = 4'b0010;

    // Write-path FSM states
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_REQ  = 4'd1,
        ST_ACT  = 4'd2,
        ST_TRCD = 4'd3,
        ST_WR   = 4'd4,
        ST_TWR  = 4'd5,
        ST_PRE  = 4'd6,
        ST_TRP  = 4'd7,
        ST_DONE = 4'd8
    } sdr_state_t;

endpackage : sdram_pkg
`default_nettype wire

// File: rtl/sdram_write.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_write
//  Description : SDRAM burst-write sequencer. A wr_trig pulse latches the
//                bank/row/column/length of a request, the block asks the
//                command arbiter for the bus (wr_req/wr_en) and then issues
//                ACTIVE -> WRITE -> data beats -> BURST_TERM -> PRECHARGE,
//                honouring tRCD, tWR and tRP, and pulses wr_done at the end.
//                Bursts stay inside the opened row; the device wraps the
//                column address modulo 256.
//
//  Ports       : clk, rst            - clock, async active-high reset
//                init_done           - SDRAM power-up complete
//                wr_trig, wr_bank, wr_row, wr_col, wr_len - request
//                wr_req / wr_en      - arbiter request / grant
//                wr_busy, wr_done    - status / completion pulse
//                fifo_rd, fifo_data  - show-ahead write FIFO interface
//                sdr_cmds, sdr_addr, sdr_ba, sdr_dq_out, sdr_dq_oe - SDRAM bus
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_write #(
    parameter int tRCD = 2,   // ACTIVE-to-WRITE, clk cycles (>=1)
    parameter int tWR  = 2,   // last data to PRECHARGE, clk cycles (>=1)
    parameter int tRP  = 3    // PRECHARGE to idle, clk cycles (>=1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        wr_trig,
    input  logic [1:0]  wr_bank,
    input  logic [10:0] wr_row,
    input  logic [7:0]  wr_col,
    input  logic [8:0]  wr_len,
    output logic        wr_req,
    input  logic        wr_en,
    output logic        wr_busy,
    output logic        wr_done,
    output logic        fifo_rd,
    input  logic [15:0] fifo_data,
    output logic [3:0]  sdr_cmds,
    output logic [10:0] sdr_addr,
    output logic [1:0]  sdr_ba,
    output logic [15:0] sdr_dq_out,
    output logic        sdr_dq_oe
);

    import sdram_pkg::*;

    // The delay counter only ever holds (param - 1) or less.
    localparam int c_dly_max = (tRCD > tWR) ? ((tRCD > tRP) ? tRCD : tRP)
                                            : ((tWR  > tRP) ? tWR  : tRP);
    localparam int c_dly_w   = (c_dly_max < 2) ? 1 : $clog2(c_dly_max);

    sdr_state_t          r_state;
    sdr_state_t          w_state_nxt;
    logic [c_dly_w-1:0]  r_dly_cnt;
    logic [c_dly_w-1:0]  w_dly_nxt;
    logic [8:0]          r_beat_cnt;
    logic [8:0]          w_beat_nxt;
    logic                w_latch;

    // Latched request
    logic [1:0]          r_bank;
    logic [10:0]         r_row;
    logic [7:0]          r_col;
    logic [8:0]          r_len;

    // Registered bus outputs and their next values
    logic [3:0]          r_cmd,    w_cmd_nxt;
    logic [10:0]         r_addr,   w_addr_nxt;
    logic [1:0]          r_ba,     w_ba_nxt;
    logic                r_dq_oe,  w_dq_oe_nxt;
    logic                r_req,    w_req_nxt;
    logic                r_busy,   w_busy_nxt;
    logic                r_done,   w_done_nxt;
    logic                r_rd,     w_rd_nxt;

    // ------------------------------------------------------------------
    // State, counters and outputs register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dly_cnt  <= '0;
            r_beat_cnt <= '0;
            r_bank     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_len      <= '0;
            r_cmd      <= c_cmd_nop;
            r_addr     <= '0;
            r_ba       <= '0;
            r_dq_oe    <= 1'b0;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dly_cnt  <= w_dly_nxt;
            r_beat_cnt <= w_beat_nxt;
            if (w_latch) begin
                r_bank <= wr_bank;
                r_row  <= wr_row;
                r_col  <= wr_col;
                r_len  <= wr_len;
            end
            r_cmd      <= w_cmd_nxt;
            r_addr     <= w_addr_nxt;
            r_ba       <= w_ba_nxt;
            r_dq_oe    <= w_dq_oe_nxt;
            r_req      <= w_req_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_rd       <= w_rd_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic. Each timed state loads its counter on
    // entry so that the state lasts exactly the required number of cycles.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly_cnt;
        w_beat_nxt  = r_beat_cnt;
        w_latch     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (wr_trig && init_done && (wr_len != 9'd0)) begin
                    w_state_nxt = ST_REQ;
                    w_latch     = 1'b1;
                end
            end
            ST_REQ: begin
                if (wr_en) begin
                    w_state_nxt = ST_ACT;
                end
            end
            ST_ACT: begin
                if (tRCD > 1) begin
                    w_state_nxt = ST_TRCD;
                    w_dly_nxt   = c_dly_w'(tRCD - 2);
                end else begin
                    w_state_nxt = ST_WR;
                    w_beat_nxt  = r_len - 9'd1;
                end
            end
            ST_TRCD: begin
                if (r_dly_cnt == '0) begin
                    w_state_nxt = ST_WR;
                    w_beat_nxt  = r_len - 9'd1;
                end else begin
                    w_dly_nxt   = r_dly_cnt - 1'b1;
                end
            end
            ST_WR: begin
                // 9-bit counter so a 256-word burst loads 255 and runs 256 beats
                if (r_beat_cnt == 9'd0) begin
                    w_state_nxt = ST_TWR;
                    w_dly_nxt   = c_dly_w'(tWR - 1);
                end else begin
                    w_beat_nxt  = r_beat_cnt - 9'd1;
                end
            end
            ST_TWR: begin
                if (r_dly_cnt == '0) begin
                    w_state_nxt = ST_PRE;
                end else begin
                    w_dly_nxt   = r_dly_cnt - 1'b1;
                end
            end
            ST_PRE: begin
                if (tRP > 1) begin
                    w_state_nxt = ST_TRP;
                    w_dly_nxt   = c_dly_w'(tRP - 2);
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_TRP: begin
                if (r_dly_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_dly_nxt   = r_dly_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the upcoming state, so that the registered
    // outputs line up with the state they belong to.
    // ------------------------------------------------------------------
    always_comb begin
        w_cmd_nxt   = c_cmd_nop;
        w_addr_nxt  = '0;
        w_ba_nxt    = '0;
        w_req_nxt   = (w_state_nxt == ST_REQ);
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        w_done_nxt  = (w_state_nxt == ST_DONE);
        w_dq_oe_nxt = (w_state_nxt == ST_WR);
        w_rd_nxt    = (w_state_nxt == ST_WR);

        if (w_state_nxt == ST_ACT) begin
            w_cmd_nxt  = c_cmd_active;
            w_addr_nxt = r_row;
            w_ba_nxt   = r_bank;
        end else if ((w_state_nxt == ST_WR) && (r_state != ST_WR)) begin
            w_cmd_nxt  = c_cmd_write;
            w_addr_nxt = {3'b000, r_col};
            w_ba_nxt   = r_bank;
        end else if ((w_state_nxt == ST_TWR) && (r_state == ST_WR)) begin
            w_cmd_nxt  = c_cmd_burst_term;
        end else if (w_state_nxt == ST_PRE) begin
            w_cmd_nxt  = c_cmd_precharge;
            w_addr_nxt = 11'h400;   // A10 high: precharge all banks
        end
    end

    assign sdr_cmds  = r_cmd;
    assign sdr_addr  = r_addr;
    assign sdr_ba    = r_ba;
    assign sdr_dq_oe = r_dq_oe;
    assign wr_req    = r_req;
    assign wr_busy   = r_busy;
    assign wr_done   = r_done;
    assign fifo_rd   = r_rd;

    // The show-ahead FIFO head advances one cycle after each fifo_rd, so the
    // word being popped is only available in the same cycle. The data bus is
    // therefore the FIFO head gated by the registered output enable: it is
    // zero whenever the bus is not driven, including in reset.
    assign sdr_dq_out = r_dq_oe ? fifo_data : 16'h0000;

endmodule : sdram_write
`default_nettype wire

// File: tb/tb_sdram_write.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sdram_write
//  Description : Self-checking bench for sdram_write. A reference model
//                derives each expected command/data cycle from the grant
//                cycle with plain offset arithmetic; a show-ahead FIFO model
//                feeds random data words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_write;

    import sdram_pkg::*;

    localparam int T_RCD = 2;
    localparam int T_WR  = 2;
    localparam int T_RP  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0;
    logic        wr_trig = 1'b0;
    logic [1:0]  wr_bank = '0;
    logic [10:0] wr_row = '0;
    logic [7:0]  wr_col = '0;
    logic [8:0]  wr_len = '0;
    logic        wr_en = 1'b0;
    logic        wr_req, wr_busy, wr_done, fifo_rd, sdr_dq_oe;
    logic [15:0] fifo_data, sdr_dq_out;
    logic [3:0]  sdr_cmds;
    logic [10:0] sdr_addr;
    logic [1:0]  sdr_ba;

    int n_cmp = 0;
    int n_err = 0;

    // Show-ahead FIFO model
    logic [15:0] fifo_mem [0:1023];
    logic [9:0]  fifo_ptr = '0;
    assign fifo_data = fifo_mem[fifo_ptr];
    always @(posedge clk) if (fifo_rd) fifo_ptr <= fifo_ptr + 10'd1;

    always #5 clk = ~clk;

    sdram_write #(.tRCD(T_RCD), .tWR(T_WR), .tRP(T_RP)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .init_done  (init_done),
        .wr_trig    (wr_trig),
        .wr_bank    (wr_bank),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_len     (wr_len),
        .wr_req     (wr_req),
        .wr_en      (wr_en),
        .wr_busy    (wr_busy),
        .wr_done    (wr_done),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .sdr_cmds   (sdr_cmds),
        .sdr_addr   (sdr_addr),
        .sdr_ba     (sdr_ba),
        .sdr_dq_out (sdr_dq_out),
        .sdr_dq_oe  (sdr_dq_oe)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Random activity on the request inputs; must never disturb a busy block
    task automatic scramble();
        wr_trig = 1'($urandom_range(0, 1));
        wr_bank = 2'($urandom);
        wr_row  = 11'($urandom);
        wr_col  = 8'($urandom);
        wr_len  = 9'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_cmd"},   sdr_cmds,   c_cmd_nop);
        check_val({tag, "_addr"},  sdr_addr,   0);
        check_val({tag, "_ba"},    sdr_ba,     0);
        check_val({tag, "_dq"},    sdr_dq_out, 0);
        check_val({tag, "_oe"},    sdr_dq_oe,  0);
        check_val({tag, "_req"},   wr_req,     0);
        check_val({tag, "_busy"},  wr_busy,    0);
        check_val({tag, "_done"},  wr_done,    0);
        check_val({tag, "_rd"},    fifo_rd,    0);
    endtask

    task automatic idle_probe(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_val({tag, "_busy"}, wr_busy,  0);
            check_val({tag, "_req"},  wr_req,   0);
            check_val({tag, "_cmd"},  sdr_cmds, c_cmd_nop);
            check_val({tag, "_oe"},   sdr_dq_oe, 0);
            @(posedge clk); #1;
        end
    endtask

    // One complete write transaction checked cycle by cycle against offsets
    // from the grant cycle. gd = cycles wr_en is withheld in REQ; noise adds
    // random triggers, request values and grants while the block is busy.
    task automatic run_write(input logic [1:0] b, input logic [10:0] r, input logic [7:0] c,
                             input int len, input int gd, input bit noise);
        int         wr_off, bt_off, pre_off, done_off, n_rd, n_oe;
        logic [9:0] base, idx;
        logic [3:0] exp_cmd;
        bit         in_wr;
        wr_off   = 1 + T_RCD;
        bt_off   = wr_off + len;
        pre_off  = bt_off + T_WR;
        done_off = pre_off + T_RP;

        @(posedge clk); #1;
        init_done = 1'b1;
        wr_bank = b; wr_row = r; wr_col = c; wr_len = 9'(len);
        wr_trig = 1'b1;
        @(posedge clk); #1;
        wr_trig = 1'b0;
        wr_en   = 1'b0;
        base    = fifo_ptr;

        for (int d = 0; d < gd; d++) begin
            if (noise) scramble();
            @(negedge clk);
            check_val("req_hold", wr_req, 1);
            check_val("req_nop", sdr_cmds, c_cmd_nop);
            @(posedge clk); #1;
        end
        wr_en = 1'b1;
        if (noise) scramble();
        @(negedge clk);
        check_val("grant_req", wr_req, 1);
        check_val("grant_busy", wr_busy, 1);
        @(posedge clk); #1;

        n_rd = 0;
        n_oe = 0;
        for (int off = 1; off <= done_off + 1; off++) begin
            if (noise && off <= done_off) begin
                scramble();
                wr_en = 1'($urandom_range(0, 1));
            end else begin
                wr_trig = 1'b0;
                wr_en   = 1'b0;
            end
            @(negedge clk);
            exp_cmd = c_cmd_nop;
            if (off == 1)        exp_cmd = c_cmd_active;
            if (off == wr_off)   exp_cmd = c_cmd_write;
            if (off == bt_off)   exp_cmd = c_cmd_burst_term;
            if (off == pre_off)  exp_cmd = c_cmd_precharge;
            check_val("cmd", sdr_cmds, exp_cmd);
            if (off == 1) begin
                check_val("act_addr", sdr_addr, r);
                check_val("act_ba", sdr_ba, b);
            end
            if (off == wr_off) begin
                check_val("wr_addr", sdr_addr, {3'b000, c});
                check_val("wr_ba", sdr_ba, b);
            end
            if (off == pre_off) check_val("pre_addr", sdr_addr, 11'h400);
            in_wr = (off >= wr_off) && (off < bt_off);
            check_val("dq_oe", sdr_dq_oe, in_wr);
            check_val("fifo_rd", fifo_rd, in_wr);
            if (in_wr) begin
                idx = base + 10'(off - wr_off);
                check_val("dq_data", sdr_dq_out, fifo_mem[idx]);
            end
            check_val("done", wr_done, off == done_off);
            check_val("busy", wr_busy, off <= done_off);
            check_val("req_off", wr_req, 0);
            n_rd += int'(fifo_rd);
            n_oe += int'(sdr_dq_oe);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        check_val("rd_count", n_rd, len);
        check_val("oe_count", n_oe, len);
    endtask

    // Global time bound
    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) fifo_mem[i] = 16'($urandom);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        idle_probe("idle", 2);

        // Trigger ignored without init_done
        init_done = 1'b0;
        wr_bank = 2'd1; wr_row = 11'h0AA; wr_col = 8'h11; wr_len = 9'd5;
        wr_trig = 1'b1;
        @(posedge clk); #1;
        wr_trig = 1'b0;
        idle_probe("no_init", 4);

        // Trigger ignored with zero length
        init_done = 1'b1;
        wr_len  = 9'd0;
        wr_trig = 1'b1;
        @(posedge clk); #1;
        wr_trig = 1'b0;
        idle_probe("len0", 4);

        // Basic transaction, grant in the same cycle as wr_req
        run_write(2'd1, 11'h155, 8'h10, 4, 0, 1'b0);
        // Grant withheld for 10 cycles
        run_write(2'd2, 11'h2AA, 8'h33, 5, 10, 1'b0);
        // Full page with column wrap
        run_write(2'd3, 11'h7FF, 8'hF0, 256, 1, 1'b0);
        // Single-beat burst
        run_write(2'd0, 11'h001, 8'hFF, 1, 0, 1'b0);
        // Mid-burst triggers and stray grants
        run_write(2'd0, 11'h123, 8'h45, 7, 2, 1'b1);

        // Reset in the middle of the data phase of an 8-beat burst
        @(posedge clk); #1;
        wr_bank = 2'd2; wr_row = 11'h321; wr_col = 8'h08; wr_len = 9'd8;
        wr_trig = 1'b1;
        @(posedge clk); #1;
        wr_trig = 1'b0;
        wr_en   = 1'b1;
        @(posedge clk); #1;
        wr_en   = 1'b0;
        repeat (T_RCD + 3) @(posedge clk);
        #1;
        check_val("mid_oe", sdr_dq_oe, 1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_probe("post_rst", 3);
        run_write(2'd1, 11'h0F0, 8'h20, 6, 1, 1'b0);

        // Randomised transactions
        for (int k = 0; k < 10; k++) begin
            run_write(2'($urandom), 11'($urandom), 8'($urandom),
                      (k % 3 == 0) ? int'($urandom_range(100, 256)) : int'($urandom_range(1, 40)),
                      int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sdram_write
`default_nettype wire
